level_controller: RTL and testbench
===================================

# level_controller

Game-flow FSM for the whack-a-mole design. It sits directly upstream of the mole display controller and the player scorer. It drives the `game` enable and the 28-bit mole `speed` those stages consume. It raises difficulty as the player's score grows, and ends the game when a fixed round timer expires.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: clock cycles per one-second tick.
- `GAME_SECONDS`, default 60: game length in seconds. Range 1..255.
- `LEVEL_SCORE`, default 10: points needed per level step. Range 1..63.
- `SPEED_BASE`, default 99_999_999: `speed` at level 0.
- `SPEED_STEP`, default 25_000_000: `speed` reduction per level. `SPEED_BASE - 3*SPEED_STEP` must be > 0.

Ports. One clock. Reset is synchronous and active-high.
- `clock`  in  1: system clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: start button, level-sensitive. Only its rising edge acts.
- `score`  in  8: current score from the player stage, unsigned.
- `game`  out  1: high while a game is running.
- `speed`  out  28: mole visible-time count for the display stage.
- `level`  out  2: current difficulty, 0..3.
- `time_left`  out  8: seconds remaining in the current game.
- `game_over`  out  1: high after a game ends, until the next start or reset.
- `hiscore`  out  8: best score recorded (see Configuration).

## Operation
- States:
  - IDLE: after reset. `game`=0.
  - PLAY: `game`=1.
  - OVER: `game`=0, `game_over`=1.
- Start edge: `start_q` is a register of `start`. `start_edge` = `start & ~start_q`.
- IDLE→PLAY, and OVER→PLAY, on `start_edge`. On entry to PLAY:
  - `level`=0, `time_left`=`GAME_SECONDS`, `tick_cnt`=0, `game_over`=0.
- `start_edge` in PLAY is ignored.
- PLAY timing:
  - `tick_cnt` counts 0..`CLK_HZ`-1, then wraps to 0. The wrap cycle is `tick`.
  - On `tick`, `time_left` decrements.
  - On `tick` with `time_left`==1: `time_left`←0, state←OVER, `game_over`←1.
- Level rule (PLAY only):
  - If `level`<3 and `score` ≥ (`level`+1)·`LEVEL_SCORE`, then `level` increments by exactly 1 that cycle.
  - Multiple thresholds already crossed are climbed one level per cycle.
  - Level never decreases, even if `score` drops.
  - Comparison width: 9-bit unsigned compare.
- `speed` is combinational from the `level` register: `SPEED_BASE` − `level`·`SPEED_STEP`, truncated to 28 bits.
- `level` and `time_left` hold their values in OVER and IDLE. They are reset only on PLAY entry or on `reset`.
- A level-up and the final `tick` in the same cycle: both take effect. Level increments and the state goes to OVER.

## Timing
- `reset` sampled high:
  - State=IDLE, `game`=0, `game_over`=0, `level`=0, `speed`=`SPEED_BASE`.
  - `time_left`=`GAME_SECONDS`, `tick_cnt`=0, `start_q`=0, `hiscore`=0.
- `reset` has priority over every other event, including mid-PLAY. `game` falls on the same edge.
- Start latency: `start` sampled high at edge k, with `start_q`=0 → `game`=1 after edge k.
- `game` is always low for ≥1 cycle before any PLAY entry. This lets the player stage clear its score.
- Game duration: exactly `GAME_SECONDS`·`CLK_HZ` cycles of `game`=1.
- `speed` changes in the same cycle as `level`.

## Configuration
- `LEVEL_CTRL_HISCORE_EN` defined:
  - On the PLAY→OVER transition, if `score` > `hiscore`, then `hiscore`←`score`. The value sampled is `score` on the transition edge.
  - `hiscore` is cleared only by `reset`.
- `LEVEL_CTRL_HISCORE_EN` undefined: `hiscore` is tied to 8'd0 and no register is built.

## Test plan
Bench parameters: `CLK_HZ`=10, `GAME_SECONDS`=3, `LEVEL_SCORE`=4, `SPEED_BASE`=100, `SPEED_STEP`=20.
- Reset, then pulse `start` for 1 cycle → `game`=1 on the next edge. `game` stays 1 for exactly 30 cycles. `time_left` steps 3→2→1→0. Then `game`=0 and `game_over`=1.
- During PLAY, set `score`=4 → `level`=1 and `speed`=80. Set `score`=13 → `level` reaches 3 over 2 cycles, `speed`=40. Set `score`=20 → `level` stays 3.
- Reach `level`=2, then lower `score` to 0 → `level` stays 2.
- Hold `start` high through a whole game → no restart, because a new rising edge is required. Release, then re-press in OVER → PLAY with `level`=0 and `time_left`=3.
- Assert `reset` mid-PLAY at `level`=2 → next edge: `game`=0, `level`=0, `speed`=100, `time_left`=3, state IDLE.
- With the macro defined: end games with `score`=7, then 5, then 9 → `hiscore` = 7, 7, 9. With the macro undefined → `hiscore`=0 throughout.

Source files
------------

// File: rtl/level_controller_if.sv
// Game-flow bus between the level controller and its surrounding game stages:
// start button and score in, game enable, mole speed, level, timer and hiscore out.
interface level_controller_if;
  logic        start;
  logic [7:0]  score;
  logic        game;
  logic [27:0] speed;
  logic [1:0]  level;
  logic [7:0]  time_left;
  logic        game_over;
  logic [7:0]  hiscore;

  modport master (
    output start, score,
    input  game, speed, level, time_left, game_over, hiscore
  );

  modport slave (
    input  start, score,
    output game, speed, level, time_left, game_over, hiscore
  );
endinterface

// File: rtl/level_controller.sv
// Whack-a-mole game-flow FSM: round timer, score-driven difficulty and mole speed.
// Optional high-score register enabled by defining LEVEL_CTRL_HISCORE_EN.
module level_controller #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int LEVEL_SCORE  = 10,
  parameter int SPEED_BASE   = 99_999_999,
  parameter int SPEED_STEP   = 25_000_000
) (
  input  logic              clock,
  input  logic              reset,
  level_controller_if.slave bus
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            start_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [7:0]      time_left_q, time_left_d;
  logic [1:0]      level_q, level_d;
  logic            start_edge;
  logic            tick;
  logic            level_up;

  // Per-level score thresholds and mole speeds, fixed at elaboration time.
  logic [8:0]  thresh_lut [4];
  logic [27:0] speed_lut  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lut
    assign thresh_lut[gi] = 9'((gi + 1) * LEVEL_SCORE);
    assign speed_lut[gi]  = 28'(SPEED_BASE - gi * SPEED_STEP);
  end

  assign start_edge = bus.start & ~start_q;
  assign tick       = (state_q == ST_PLAY) && (tick_cnt_q == TW'(CLK_HZ - 1));
  assign level_up   = (level_q != 2'd3) && ({1'b0, bus.score} >= thresh_lut[level_q]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      tick_cnt_q  <= '0;
      time_left_q <= 8'(GAME_SECONDS);
      level_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      tick_cnt_q  <= tick_cnt_d;
      time_left_q <= time_left_d;
      level_q     <= level_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    time_left_d = time_left_q;
    level_d     = level_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_PLAY;
          tick_cnt_d  = '0;
          time_left_d = 8'(GAME_SECONDS);
          level_d     = 2'd0;
        end
      end
      ST_PLAY: begin
        // A level-up on the final tick still lands before the game ends.
        if (level_up) begin
          level_d = level_q + 2'd1;
        end
        if (tick) begin
          tick_cnt_d  = '0;
          time_left_d = time_left_q - 8'd1;
          if (time_left_q == 8'd1) begin
            state_d = ST_OVER;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.game      = (state_q == ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.level     = level_q;
  assign bus.time_left = time_left_q;
  assign bus.speed     = speed_lut[level_q];

`ifdef LEVEL_CTRL_HISCORE_EN
  logic [7:0] hiscore_q;

  // Score is sampled on the very edge that ends the game.
  always_ff @(posedge clock) begin
    if (reset) begin
      hiscore_q <= 8'd0;
    end else if ((state_q == ST_PLAY) && (state_d == ST_OVER) && (bus.score > hiscore_q)) begin
      hiscore_q <= bus.score;
    end
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = 8'd0;
`endif

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: directed game scenarios plus random
// start/score/reset traffic compared against an elapsed-time game model.
module tb_level_controller;
  localparam int CLK_HZ       = 10;
  localparam int GAME_SECONDS = 3;
  localparam int LEVEL_SCORE  = 4;
  localparam int SPEED_BASE   = 100;
  localparam int SPEED_STEP   = 20;
  localparam int GAME_CYCLES  = GAME_SECONDS * CLK_HZ;

  logic clock = 1'b0;
  logic reset = 1'b1;

  level_controller_if bus ();

  level_controller #(
    .CLK_HZ      (CLK_HZ),
    .GAME_SECONDS(GAME_SECONDS),
    .LEVEL_SCORE (LEVEL_SCORE),
    .SPEED_BASE  (SPEED_BASE),
    .SPEED_STEP  (SPEED_STEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = idle, 1 = playing, 2 = finished; time derived from elapsed cycles.
  int m_phase   = 0;
  int m_level   = 0;
  int m_elapsed = 0;
  int m_hiscore = 0;
  bit m_prev_start = 1'b0;

  function automatic void model_edge(input bit rst, input bit st, input int sc);
    if (rst) begin
      m_phase = 0; m_level = 0; m_elapsed = 0; m_hiscore = 0; m_prev_start = 1'b0;
      return;
    end
    if (m_phase == 1) begin
      if (m_level < 3 && sc >= (m_level + 1) * LEVEL_SCORE) m_level = m_level + 1;
      m_elapsed = m_elapsed + 1;
      if (m_elapsed == GAME_CYCLES) begin
        m_phase = 2;
        if (sc > m_hiscore) m_hiscore = sc;
      end
    end else if (st && !m_prev_start) begin
      m_phase = 1; m_level = 0; m_elapsed = 0;
    end
    m_prev_start = st;
  endfunction

  function automatic int exp_time();
    return GAME_SECONDS - m_elapsed / CLK_HZ;
  endfunction

  function automatic int exp_speed();
    return SPEED_BASE - m_level * SPEED_STEP;
  endfunction

  function automatic int exp_hiscore();
`ifdef LEVEL_CTRL_HISCORE_EN
    return m_hiscore;
`else
    return 0;
`endif
  endfunction

  task automatic cycle(input bit rst, input bit st, input int sc);
    reset     = rst;
    bus.start = st;
    bus.score = 8'(sc);
    @(posedge clock);
    model_edge(rst, st, sc);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    checks++; if (bus.game !== 1'b0) begin errors++; $display("FAIL reset_game: got %0b want 0", bus.game); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0b want 0", bus.game_over); end
    checks++; if (int'(bus.level) !== 0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    checks++; if (int'(bus.speed) !== SPEED_BASE) begin errors++; $display("FAIL reset_speed: got %0d want %0d", bus.speed, SPEED_BASE); end
    checks++; if (int'(bus.time_left) !== GAME_SECONDS) begin errors++; $display("FAIL reset_time_left: got %0d want %0d", bus.time_left, GAME_SECONDS); end
    checks++; if (int'(bus.hiscore) !== 0) begin errors++; $display("FAIL reset_hiscore: got %0d want 0", bus.hiscore); end
    $display("reset: game=%0b level=%0d speed=%0d time_left=%0d", bus.game, bus.level, bus.speed, bus.time_left);
  endtask

  task automatic test_game_duration();
    int n;
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    checks++; if (bus.game !== 1'b1) begin errors++; $display("FAIL start_latency: game=%0b want 1", bus.game); end
    n = (bus.game === 1'b1) ? 1 : 0;
    for (int i = 0; i < 100 && bus.game === 1'b1; i++) begin
      cycle(1'b0, 1'b0, 0);
      if (bus.game === 1'b1) n++;
      checks++;
      if (int'(bus.time_left) !== exp_time()) begin
        errors++; $display("FAIL time_left_step: cycle %0d got %0d want %0d", i, bus.time_left, exp_time());
      end
    end
    checks++; if (n !== GAME_CYCLES) begin errors++; $display("FAIL game_duration: got %0d cycles want %0d", n, GAME_CYCLES); end
    checks++; if (bus.game_over !== 1'b1 || bus.game !== 1'b0) begin
      errors++; $display("FAIL game_end: game=%0b game_over=%0b want 0/1", bus.game, bus.game_over);
    end
    checks++; if (int'(bus.time_left) !== 0) begin errors++; $display("FAIL time_left_end: got %0d want 0", bus.time_left); end
    $display("game: %0d cycles of play, time_left=%0d game_over=%0b", n, bus.time_left, bus.game_over);
  endtask

  task automatic finish_game(input int sc);
    for (int i = 0; i < 100 && bus.game === 1'b1; i++) cycle(1'b0, 1'b0, sc);
    checks++; if (bus.game !== 1'b0) begin errors++; $display("FAIL game_timeout: game still %0b", bus.game); end
  endtask

  task automatic test_level_climb();
    int scores [4] = '{4, 13, 13, 20};
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    foreach (scores[k]) begin
      cycle(1'b0, 1'b0, scores[k]);
      checks++; if (int'(bus.level) !== m_level) begin errors++; $display("FAIL level_climb[%0d]: got %0d want %0d", k, bus.level, m_level); end
      checks++; if (int'(bus.speed) !== exp_speed()) begin errors++; $display("FAIL speed_climb[%0d]: got %0d want %0d", k, bus.speed, exp_speed()); end
      $display("level: score=%0d level=%0d speed=%0d", scores[k], bus.level, bus.speed);
    end
    checks++; if (int'(bus.speed) !== SPEED_BASE - 3 * SPEED_STEP) begin errors++; $display("FAIL speed_top: got %0d want %0d", bus.speed, SPEED_BASE - 3 * SPEED_STEP); end
    finish_game(20);
  endtask

  task automatic test_no_decrease();
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 8);
    cycle(1'b0, 1'b0, 8);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0);
    checks++; if (int'(bus.level) !== 2 || m_level !== 2) begin errors++; $display("FAIL level_hold: got %0d want 2", bus.level); end
    $display("no_decrease: level=%0d after score drop", bus.level);
    finish_game(0);
  endtask

  task automatic test_hold_start();
    cycle(1'b0, 1'b0, 0);
    for (int i = 0; i < GAME_CYCLES + 10; i++) cycle(1'b0, 1'b1, 0);
    checks++; if (bus.game !== 1'b0 || bus.game_over !== 1'b1) begin
      errors++; $display("FAIL held_start: game=%0b game_over=%0b want 0/1", bus.game, bus.game_over);
    end
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    checks++; if (bus.game !== 1'b1 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL restart: game=%0b game_over=%0b want 1/0", bus.game, bus.game_over);
    end
    checks++; if (int'(bus.level) !== 0 || int'(bus.time_left) !== GAME_SECONDS) begin
      errors++; $display("FAIL restart_state: level=%0d time_left=%0d want 0/%0d", bus.level, bus.time_left, GAME_SECONDS);
    end
    $display("hold_start: restart game=%0b level=%0d time_left=%0d", bus.game, bus.level, bus.time_left);
  endtask

  task automatic test_reset_mid_play();
    cycle(1'b0, 1'b0, 8);
    cycle(1'b0, 1'b0, 8);
    checks++; if (int'(bus.level) !== 2) begin errors++; $display("FAIL pre_reset_level: got %0d want 2", bus.level); end
    cycle(1'b1, 1'b0, 8);
    checks++; if (bus.game !== 1'b0 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: game=%0b game_over=%0b want 0/0", bus.game, bus.game_over);
    end
    checks++; if (int'(bus.level) !== 0 || int'(bus.speed) !== SPEED_BASE || int'(bus.time_left) !== GAME_SECONDS) begin
      errors++; $display("FAIL midreset_values: level=%0d speed=%0d time_left=%0d want 0/%0d/%0d",
                         bus.level, bus.speed, bus.time_left, SPEED_BASE, GAME_SECONDS);
    end
    $display("reset_mid_play: game=%0b level=%0d speed=%0d", bus.game, bus.level, bus.speed);
  endtask

  task automatic test_hiscore();
    int finals [3] = '{7, 5, 9};
`ifdef LEVEL_CTRL_HISCORE_EN
    int wants [3] = '{7, 7, 9};
`else
    int wants [3] = '{0, 0, 0};
`endif
    foreach (finals[k]) begin
      cycle(1'b0, 1'b0, finals[k]);
      cycle(1'b0, 1'b1, finals[k]);
      finish_game(finals[k]);
      checks++; if (int'(bus.hiscore) !== wants[k] || wants[k] !== exp_hiscore()) begin
        errors++; $display("FAIL hiscore[%0d]: got %0d want %0d", k, bus.hiscore, wants[k]);
      end
      $display("hiscore: final score=%0d hiscore=%0d", finals[k], bus.hiscore);
    end
  endtask

  task automatic test_random();
    bit st = 1'b0;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      bit r = ($urandom_range(0, 249) == 0);
      int sc = int'($urandom_range(0, 20));
      if ($urandom_range(0, 14) == 0) st = ~st;
      cycle(r, st, sc);
      checks++;
      if (bus.game !== (m_phase == 1) || bus.game_over !== (m_phase == 2) ||
          int'(bus.level) !== m_level || int'(bus.speed) !== exp_speed() ||
          int'(bus.time_left) !== exp_time() || int'(bus.hiscore) !== exp_hiscore()) begin
        errors++; bad++;
        $display("FAIL random[%0d]: game=%0b over=%0b lvl=%0d spd=%0d t=%0d hs=%0d want %0b/%0b/%0d/%0d/%0d/%0d",
                 i, bus.game, bus.game_over, bus.level, bus.speed, bus.time_left, bus.hiscore,
                 (m_phase == 1), (m_phase == 2), m_level, exp_speed(), exp_time(), exp_hiscore());
      end
    end
    $display("random: 600 cycles, %0d discrepancies", bad);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.score = 8'd0;
    test_reset();
    test_game_duration();
    test_level_climb();
    test_no_decrease();
    test_hold_start();
    test_reset_mid_play();
    test_hiscore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
